// File: rtl/nn_param_loader.sv
// nn_param_loader: turns a byte stream of fixed-point parameters into write
// strobes for the weight memory followed by the bias memory.
// Words arrive least-significant byte first. Each assembled word is written
// one cycle after its last byte is accepted.
// Optional feature: define NN_PARAM_LOADER_CHECKSUM_EN to consume one trailing
// XOR checksum byte after the biases. A mismatch raises err together with done.
module nn_param_loader #(
    parameter int NUM_WEIGHTS = 495,
    parameter int NUM_BIASES  = 47,
    parameter int PARAM_WIDTH = 16,
    parameter int W_ADDR_W    = $clog2(NUM_WEIGHTS),
    parameter int B_ADDR_W    = $clog2(NUM_BIASES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   w_we,
    output logic [W_ADDR_W-1:0]    w_addr,
    output logic [PARAM_WIDTH-1:0] w_data,
    output logic                   b_we,
    output logic [B_ADDR_W-1:0]    b_addr,
    output logic [PARAM_WIDTH-1:0] b_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int BYTES_PER_PARAM = PARAM_WIDTH / 8;
    localparam int BC_W  = (BYTES_PER_PARAM > 1) ? $clog2(BYTES_PER_PARAM) : 1;
    localparam int CNT_W = (W_ADDR_W > B_ADDR_W) ? W_ADDR_W : B_ADDR_W;

    localparam logic [BC_W-1:0]  BYTE_LAST = BC_W'(BYTES_PER_PARAM - 1);
    localparam logic [CNT_W-1:0] W_LAST    = CNT_W'(NUM_WEIGHTS - 1);
    localparam logic [CNT_W-1:0] B_LAST    = CNT_W'(NUM_BIASES - 1);

`ifdef NN_PARAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_WEIGHTS, S_BIASES, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WEIGHTS, S_BIASES, S_DONE} state_t;
`endif

    state_t                   state_q, state_d;
    logic [BC_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;
    logic [PARAM_WIDTH-1:0]   asm_q, asm_d;
    logic                     w_we_q, w_we_d;
    logic [W_ADDR_W-1:0]      w_addr_q, w_addr_d;
    logic [PARAM_WIDTH-1:0]   w_data_q, w_data_d;
    logic                     b_we_q, b_we_d;
    logic [B_ADDR_W-1:0]      b_addr_q, b_addr_d;
    logic [PARAM_WIDTH-1:0]   b_data_q, b_data_d;
    logic                     done_q, done_d;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
    logic                     err_q, err_d;
`endif

    logic                     load_active;
    logic                     fire;
    logic                     last_byte;
    logic [PARAM_WIDTH-1:0]   word;

    // Stream is accepted only while a load is in progress.
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
    assign load_active = (state_q == S_WEIGHTS) || (state_q == S_BIASES) || (state_q == S_CHECK);
`else
    assign load_active = (state_q == S_WEIGHTS) || (state_q == S_BIASES);
`endif
    assign fire      = in_valid && load_active;
    assign last_byte = (byte_cnt_q == BYTE_LAST);
    // Current byte merged into its lane on top of the bytes already collected.
    assign word      = asm_q | (PARAM_WIDTH'(in_data) << {byte_cnt_q, 3'b000});

    // Next-state, byte assembly, address sequencing and write-strobe generation.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        w_we_d     = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        b_we_d     = 1'b0;
        b_addr_d   = b_addr_q;
        b_data_d   = b_data_q;
        // done rises one cycle after entering DONE, which is after the final write strobe.
        done_d     = (state_q == S_DONE) && !start;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_WEIGHTS;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    asm_d      = '0;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
                    err_d      = 1'b0;
`endif
                end
            end
            S_WEIGHTS, S_BIASES: begin
                if (fire) begin
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (!last_byte) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        asm_d      = word;
                    end else begin
                        byte_cnt_d = '0;
                        asm_d      = '0;
                        if (state_q == S_WEIGHTS) begin
                            w_we_d   = 1'b1;
                            w_addr_d = W_ADDR_W'(word_cnt_q);
                            w_data_d = word;
                            if (word_cnt_q == W_LAST) begin
                                word_cnt_d = '0;
                                state_d    = S_BIASES;
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                            end
                        end else begin
                            b_we_d   = 1'b1;
                            b_addr_d = B_ADDR_W'(word_cnt_q);
                            b_data_d = word;
                            if (word_cnt_q == B_LAST) begin
                                word_cnt_d = '0;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
                                state_d    = S_CHECK;
`else
                                state_d    = S_DONE;
`endif
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                            end
                        end
                    end
                end
            end
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                // The trailing byte must equal the XOR of every parameter byte.
                if (fire) begin
                    err_d   = (in_data != csum_q);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending write strobe.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            w_we_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            b_we_q     <= 1'b0;
            b_addr_q   <= '0;
            b_data_q   <= '0;
            done_q     <= 1'b0;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            w_we_q     <= w_we_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            b_we_q     <= b_we_d;
            b_addr_q   <= b_addr_d;
            b_data_q   <= b_data_d;
            done_q     <= done_d;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            err_q      <= err_d;
`endif
        end
    end

    assign in_ready = load_active;
    // Stay busy through the final write strobe until done is raised.
    assign busy     = load_active || ((state_q == S_DONE) && !done_q);
    assign done     = done_q;
    assign w_we     = w_we_q;
    assign w_addr   = w_addr_q;
    assign w_data   = w_data_q;
    assign b_we     = b_we_q;
    assign b_addr   = b_addr_q;
    assign b_data   = b_data_q;
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_nn_param_loader.sv
// tb_nn_param_loader: drives parameter streams into nn_param_loader and checks
// the resulting write strobes against per-address parameter tables.
// Also checks completion timing, reset behaviour and start handling.
// Honours NN_PARAM_LOADER_CHECKSUM_EN in the same way as the design.
module tb_nn_param_loader;

    localparam int NW  = 495;
    localparam int NB  = 47;
    localparam int PW  = 16;
    localparam int BPP = PW / 8;
    localparam int WAW = 9;
    localparam int BAW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          w_we;
    logic [WAW-1:0] w_addr;
    logic [PW-1:0] w_data;
    logic          b_we;
    logic [BAW-1:0] b_addr;
    logic [PW-1:0] b_data;
    logic          busy;
    logic          done;
    logic          err;

    nn_param_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int ready_drops;

    // Reference content: what each memory address must hold after a load.
    logic [PW-1:0] wparam [NW];
    logic [PW-1:0] bparam [NB];
    logic [7:0]    stream [$];

    typedef struct packed { logic [WAW-1:0] a; logic [PW-1:0] d; } wrec_t;
    typedef struct packed { logic [BAW-1:0] a; logic [PW-1:0] d; } brec_t;
    wrec_t obs_w [$];
    brec_t obs_b [$];

    // Observed write strobes, sampled away from the rising edge.
    always @(negedge clk) begin
        if (w_we === 1'b1) obs_w.push_back({w_addr, w_data});
        if (b_we === 1'b1) obs_b.push_back({b_addr, b_data});
    end

    function automatic void fill(input bit rnd);
        for (int n = 0; n < NW; n++) wparam[n] = rnd ? PW'($urandom) : PW'(n);
        for (int m = 0; m < NB; m++) bparam[m] = rnd ? PW'($urandom) : (16'h8000 | PW'(m));
    endfunction

    // Byte stream: LSB first, weights then biases, optional XOR trailer.
    function automatic void build_stream(input bit flip);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        stream.delete();
        for (int n = 0; n < NW; n++)
            for (int k = 0; k < BPP; k++) begin b = wparam[n][8*k +: 8]; stream.push_back(b); x ^= b; end
        for (int m = 0; m < NB; m++)
            for (int k = 0; k < BPP; k++) begin b = bparam[m][8*k +: 8]; stream.push_back(b); x ^= b; end
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
        stream.push_back(flip ? ~x : x);
`else
        if (flip) x = ~x;
`endif
    endfunction

    function automatic int w_errs();
        int e = 0;
        if (obs_w.size() != NW) e++;
        foreach (obs_w[i]) begin
            if (i >= NW) e++;
            else if (obs_w[i] !== {WAW'(i), wparam[i]}) e++;
        end
        return e;
    endfunction

    function automatic int b_errs();
        int e = 0;
        if (obs_b.size() != NB) e++;
        foreach (obs_b[i]) begin
            if (i >= NB) e++;
            else if (obs_b[i] !== {BAW'(i), bparam[i]}) e++;
        end
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that sampled start.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends stream[0..nbytes-1]; random idle gaps; optional start pulse on byte start_at.
    task automatic send_stream(input int nbytes, input int gap_pct, input int start_at);
        for (int i = 0; i < nbytes; i++) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                in_valid = 1'b0; in_data = 8'($urandom); start = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = stream[i];
            start    = (i == start_at);
            @(negedge clk);
            if (in_ready !== 1'b1) ready_drops++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({in_ready, w_we, b_we, w_addr, b_addr, w_data, b_data, busy, done, err} !== '0)
            $display("FAIL reset_values: got %h expected 0", {in_ready, w_we, b_we, w_addr, b_addr, w_data, b_data, busy, done, err});
        else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if ({in_ready, busy, done} !== 3'b000)
            $display("FAIL idle_after_reset: got %b expected 000", {in_ready, busy, done});
        else passed++;
    endtask

    task automatic test_byte_order();
        do_start();
        in_valid = 1'b1; in_data = 8'h34;
        @(posedge clk); #1;
        total++; if (w_we !== 1'b0) $display("FAIL byte_order_early: w_we got %b expected 0", w_we); else passed++;
        in_data = 8'h12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if ({w_we, w_addr, w_data} !== {1'b1, 9'd0, 16'h1234})
            $display("FAIL byte_order: got we=%b addr=%0d data=%h expected we=1 addr=0 data=1234", w_we, w_addr, w_data);
        else passed++;
        @(posedge clk); #1;
        total++; if (w_we !== 1'b0) $display("FAIL byte_order_pulse: w_we got %b expected 0", w_we); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One complete load with the given stimulus and completion checks.
    task automatic test_load(input string name, input bit rnd, input int gap_pct, input int start_at, input bit flip);
        fill(rnd);
        build_stream(flip);
        obs_w.delete();
        obs_b.delete();
        ready_drops = 0;
        do_start();
        total++; if ({busy, in_ready, done, err} !== 4'b1100)
            $display("FAIL %s start: busy,ready,done,err got %b expected 1100", name, {busy, in_ready, done, err});
        else passed++;
        send_stream(stream.size(), gap_pct, start_at);
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
        total++; if ({done, busy, in_ready, err} !== {1'b1, 1'b0, 1'b0, flip})
            $display("FAIL %s csum_end: done,busy,ready,err got %b expected %b", name, {done, busy, in_ready, err}, {1'b1, 1'b0, 1'b0, flip});
        else passed++;
`else
        total++; if ({b_we, done, in_ready} !== 3'b100)
            $display("FAIL %s last_strobe: b_we,done,ready got %b expected 100", name, {b_we, done, in_ready});
        else passed++;
        @(posedge clk); #1;
        total++; if ({b_we, done, busy, in_ready, err} !== 5'b01000)
            $display("FAIL %s finish: b_we,done,busy,ready,err got %b expected 01000", name, {b_we, done, busy, in_ready, err});
        else passed++;
`endif
        @(posedge clk); #1;
        total++; if ({done, err} !== {1'b1, flip})
            $display("FAIL %s done_hold: done,err got %b expected %b", name, {done, err}, {1'b1, flip});
        else passed++;
        total++; if (ready_drops !== 0) $display("FAIL %s ready_drops: got %0d expected 0", name, ready_drops); else passed++;
        total++; if (w_errs() !== 0)
            $display("FAIL %s weight_writes: %0d bad of %0d strobes, expected %0d good", name, w_errs(), obs_w.size(), NW);
        else passed++;
        total++; if (b_errs() !== 0)
            $display("FAIL %s bias_writes: %0d bad of %0d strobes, expected %0d good", name, b_errs(), obs_b.size(), NB);
        else passed++;
    endtask

    task automatic test_reset_midload();
        fill(1'b1);
        build_stream(1'b0);
        do_start();
        send_stream(300, 0, -1);
        #2;
        rst = 1'b1;
        #1;
        total++; if ({in_ready, w_we, b_we, w_addr, b_addr, w_data, b_data, busy, done, err} !== '0)
            $display("FAIL midload_reset: got %h expected 0", {in_ready, w_we, b_we, w_addr, b_addr, w_data, b_data, busy, done, err});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_load("after_reset", 1'b1, 0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_byte_order();
        test_load("full_load_b2b", 1'b0, 0, -1, 1'b0);
        test_load("start_while_busy", 1'b1, 0, 400, 1'b0);
        test_load("start_in_done", 1'b1, 0, -1, 1'b0);
        test_load("backpressure", 1'b1, 50, -1, 1'b0);
        test_reset_midload();
`ifdef NN_PARAM_LOADER_CHECKSUM_EN
        test_load("csum_bad", 1'b1, 20, -1, 1'b1);
        test_load("csum_good", 1'b1, 20, -1, 1'b0);
`else
        test_load("no_csum_gaps", 1'b1, 20, -1, 1'b0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nn_param_loader.md
# nn_param_loader

Streaming parameter loader for the MLP inference core: accepts a byte stream of fixed-point weights and biases (e.g. from the host UART/SPI bridge) and writes them into the weight and bias memories read by the NN datapath. It is the writer end of the parameter-memory interface whose reader is the layer engine. Load order, counts and word width match the model parameters of the NN package.

## Interface

Parameters:
- NUM_WEIGHTS, 495, number of weight words to load.
- NUM_BIASES, 47, number of bias words to load.
- PARAM_WIDTH, 16, parameter word width in bits; must be a multiple of 8. BYTES_PER_PARAM = PARAM_WIDTH/8.
- W_ADDR_W, $clog2(NUM_WEIGHTS) = 9, weight address width.
- B_ADDR_W, $clog2(NUM_BIASES) = 6, bias address width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled in IDLE or DONE only.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte; parameters are sent least-significant byte first.
- in_ready  out  1  loader accepts a byte this cycle.
- w_we  out  1  weight memory write strobe.
- w_addr  out  W_ADDR_W  weight write address.
- w_data  out  PARAM_WIDTH  weight write data (Q2.14 two's complement, passed through unchanged).
- b_we  out  1  bias memory write strobe.
- b_addr  out  B_ADDR_W  bias write address.
- b_data  out  PARAM_WIDTH  bias write data.
- busy  out  1  load in progress.
- done  out  1  load finished; held until next start or reset.
- err  out  1  checksum mismatch on last load; valid while done=1.

## Operation

- States: IDLE, WEIGHTS, BIASES, CHECK, DONE.
- IDLE --start--> WEIGHTS. DONE --start--> WEIGHTS (clears done, err). start in any other state is ignored.
- Byte handshake: byte consumed on cycle where in_valid && in_ready. in_ready=1 only in WEIGHTS, BIASES, CHECK. Bytes presented in IDLE/DONE are not consumed.
- Byte assembly: byte counter 0..BYTES_PER_PARAM-1; byte k goes to bits [8k+7:8k]. On the final byte of a word the assembled word is written.
- WEIGHTS: word n written to w_addr=n, n = 0..NUM_WEIGHTS-1. After word NUM_WEIGHTS-1 → BIASES.
- BIASES: word m written to b_addr=m, m = 0..NUM_BIASES-1. After word NUM_BIASES-1 → CHECK (checksum enabled) or DONE.
- CHECK: consumes one byte, compares against running checksum, → DONE.
- busy=1 in WEIGHTS, BIASES, CHECK.
- Loader never reads memories and never clears them; partially written content stays after abort.

## Timing

- Reset values: in_ready=0, w_we=0, b_we=0, w_addr=0, b_addr=0, w_data=0, b_data=0, busy=0, done=0, err=0; state IDLE, all counters 0, checksum 0.
- start accepted at edge t: busy=1 and in_ready=1 from t+1.
- Write latency: w_we/b_we asserted exactly one cycle (registered) in the cycle after the final byte of a word is accepted; addr/data valid in the same cycle. One-cycle pulse per word.
- Full throughput: one byte per cycle with in_valid held high; in_ready stays 1 throughout (no bubbles, including WEIGHTS→BIASES boundary). Total load = 2·(NUM_WEIGHTS+NUM_BIASES) bytes (+1 checksum).
- in_valid gaps: state and counters hold; no write issued.
- Last word: done=1, busy=0, in_ready=0 in the cycle after the last bias write strobe (or after checksum byte accepted when enabled); in_ready deasserts the cycle the last byte is accepted.
- Reset mid-load: immediate return to IDLE with reset values; any pending write strobe is dropped.

## Configuration

- NN_PARAM_LOADER_CHECKSUM_EN defined: running XOR over every parameter byte accepted; after the last bias one extra byte is consumed in CHECK. err=1 with done=1 if it differs from the running XOR, else err=0. Memory writes are not reverted on mismatch.
- Not defined: CHECK state absent, BIASES → DONE directly, err tied to 0, no trailing byte consumed.

## Test plan

- Full load, back-to-back bytes: weight n = n, bias m = 16'h8000|m → 495 w_we pulses with w_addr=n, w_data=n; 47 b_we pulses with b_data=16'h8000|m; done=1 one cycle after final strobe.
- Byte order: first word bytes 0x34,0x12 → w_addr=0, w_data=16'h1234 one cycle after second byte.
- Backpressure: in_valid toggled randomly 50% → same write sequence as back-to-back, no extra or missing strobes.
- Reset asserted after 300 bytes accepted → all outputs at reset values immediately; new start then full load completes correctly from w_addr=0.
- start pulsed while busy at word 200 → ignored, addresses continue uninterrupted; start in DONE → done clears, new load begins.
- With NN_PARAM_LOADER_CHECKSUM_EN: correct XOR byte → done=1, err=0; inverted XOR byte → done=1, err=1; without macro, err stays 0 and 1084 bytes complete the load.
